// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON packet wrapper.
// Holds the word size, the round count, the Z3 constant, the packet identifiers,
// the packet and FSM types, and the rotate and z-bit helpers.
package simon_pkg;

    localparam int N = 32;
    // Round count for SIMON with a four-word key, chosen by word size.
    localparam int T = (N == 16) ? 32 : (N == 24) ? 36 : (N == 32) ? 44 : 72;
    localparam int CNT_W = $clog2(T);

    // The MSB of this literal is sequence bit 0.
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    localparam logic [7:0] ID_KEY  = 8'h01;
    localparam logic [7:0] ID_DATA = 8'h02;

    typedef logic [N/2+1:0][7:0] pkt_t;
    typedef logic [N-1:0] word_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    function automatic word_t rotl(word_t v, int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic word_t rotr(word_t v, int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    function automatic logic zBit(logic [5:0] idx);
        return Z3[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_top_pkt_if.sv
// Packet transport bundle between a byte-packet source/sink and simon_top_pkt.
// Ports:
//   in_newPKT / in / in_loadPKT : 4-phase request, packet, acknowledge
//   in_donePKT                  : captured packet fully processed (pulse)
//   out_donePKT / out / out_readPKT : result valid, result packet, sink consumed
// master = transport side, slave = encryptor side.
interface simon_top_pkt_if;
    import simon_pkg::*;

    logic in_newPKT;
    pkt_t in;
    logic in_loadPKT;
    logic in_donePKT;
    logic out_readPKT;
    logic out_donePKT;
    pkt_t out;

    modport master (
        output in_newPKT, in, out_readPKT,
        input  in_loadPKT, in_donePKT, out_donePKT, out
    );

    modport slave (
        input  in_newPKT, in, out_readPKT,
        output in_loadPKT, in_donePKT, out_donePKT, out
    );

endinterface

// File: rtl/simon_round_core.sv
// One SIMON round plus one key-schedule step, purely combinational.
// Ports:
//   x, y      : current block halves (x = upper word)
//   kw0..kw3  : key window k_i, k_{i+1}, k_{i+3} (k_{i+2} not needed)
//   roundIdx  : i, selects the Z3 bit
//   xNext, yNext : block after the round
//   kNew      : k_{i+4}
module simon_round_core
    import simon_pkg::*;
(
    input  word_t      x,
    input  word_t      y,
    input  word_t      kw0,
    input  word_t      kw1,
    input  word_t      kw3,
    input  logic [5:0] roundIdx,
    output word_t      xNext,
    output word_t      yNext,
    output word_t      kNew
);

    word_t t;

    always_comb begin
        t     = rotr(kw3, 3) ^ kw1;
        xNext = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ kw0;
        yNext = x;
        kNew  = ~kw0 ^ t ^ rotr(t, 1) ^ {{(N-1){1'b0}}, zBit(roundIdx)} ^ word_t'(3);
    end

endmodule

// File: rtl/simon_top_pkt.sv
// Packet-level wrapper around an iterative SIMON64/128 encryptor.
// Key packets load the key; data packets carry two blocks that are encrypted
// one round per clock and returned as a single result packet.
// Ports:
//   clk  : clock, rising edge
//   nR   : asynchronous active-low reset
//   bus  : packet transport (slave modport)
//
// state | meaning
// IDLE  | waiting for a request while no unread result is pending
// LOAD  | packet latched, acknowledge held until the request drops
// RUN   | encrypting block0 then block1, one round per clock
// DONE  | publishing the result packet
module simon_top_pkt
    import simon_pkg::*;
(
    input  logic clk,
    input  logic nR,
    simon_top_pkt_if.slave bus
);

    state_t state, stateNext;

    pkt_t               pktReg;
    logic [4*N-1:0]     keyReg;
    logic               keyValid;
    word_t              x, y;
    logic [3:0][N-1:0]  kSched;
    logic [CNT_W-1:0]   roundCnt;
    logic               blockSel;
    logic [2*N-1:0]     ct0;
    logic               loadReg, doneReg, outValid;
    pkt_t               outReg;

    logic capture, keyWr, startRun, pktDone, finish, lastRound;
    word_t xNext, yNext, kNew;
    logic [4*N-1:0] payload;
    logic [7:0] pktId;

    assign payload   = pktReg[N/2-1:0];
    assign pktId     = pktReg[N/2+1];
    assign lastRound = (roundCnt == CNT_W'(T - 1));

    simon_round_core uCore (
        .x        (x),
        .y        (y),
        .kw0      (kSched[0]),
        .kw1      (kSched[1]),
        .kw3      (kSched[3]),
        .roundIdx (roundCnt),
        .xNext    (xNext),
        .yNext    (yNext),
        .kNew     (kNew)
    );

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        keyWr     = 1'b0;
        startRun  = 1'b0;
        pktDone   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // An unread result blocks capture so it cannot be overwritten.
                if (bus.in_newPKT && !outValid) begin
                    capture   = 1'b1;
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                if (!bus.in_newPKT) begin
                    if (pktId == ID_KEY) begin
                        keyWr     = 1'b1;
                        pktDone   = 1'b1;
                        stateNext = IDLE;
                    end else if (pktId == ID_DATA && keyValid) begin
                        startRun  = 1'b1;
                        stateNext = RUN;
                    end else begin
                        pktDone   = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            RUN: begin
                if (lastRound && blockSel) stateNext = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                pktDone   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            pktReg   <= '0;
            keyReg   <= '0;
            keyValid <= 1'b0;
            x        <= '0;
            y        <= '0;
            kSched   <= '0;
            roundCnt <= '0;
            blockSel <= 1'b0;
            ct0      <= '0;
            loadReg  <= 1'b0;
            doneReg  <= 1'b0;
            outValid <= 1'b0;
            outReg   <= '0;
        end else begin
            loadReg <= (stateNext == LOAD);
            doneReg <= pktDone;

            if (capture) pktReg <= bus.in;

            if (keyWr) begin
                keyReg   <= payload;
                keyValid <= 1'b1;
            end

            if (startRun) begin
                x        <= payload[4*N-1:3*N];
                y        <= payload[3*N-1:2*N];
                kSched   <= keyReg;
                roundCnt <= '0;
                blockSel <= 1'b0;
            end else if (state == RUN) begin
                x <= xNext;
                y <= yNext;
                if (lastRound && !blockSel) begin
                    // Block0 finished: park it and restart the schedule for block1.
                    ct0      <= {xNext, yNext};
                    x        <= payload[2*N-1:N];
                    y        <= payload[N-1:0];
                    kSched   <= keyReg;
                    roundCnt <= '0;
                    blockSel <= 1'b1;
                end else if (!lastRound) begin
                    kSched   <= {kNew, kSched[3:1]};
                    roundCnt <= roundCnt + 1'b1;
                end
            end

            if (finish) begin
                outReg   <= {ID_DATA, pktReg[N/2], ct0, x, y};
                outValid <= 1'b1;
            end else if (outValid && bus.out_readPKT) begin
                outValid <= 1'b0;
            end
        end
    end

    assign bus.in_loadPKT  = loadReg;
    assign bus.in_donePKT  = doneReg;
    assign bus.out_donePKT = outValid;
    assign bus.out         = outReg;

endmodule

// File: tb/tb_simon_top_pkt.sv
module tb_simon_top_pkt;
    import simon_pkg::*;

    logic clk = 1'b0;
    logic nR;
    always #5 clk = ~clk;

    simon_top_pkt_if bus();

    simon_top_pkt dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus.slave)
    );

    int   nTests = 0;
    int   nFail  = 0;
    pkt_t sbQ[$];
    int   donePulses = 0;
    int   outRises = 0;
    logic prevOutDone = 1'b0;

    localparam logic [127:0] KEY0 = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] KEY1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [63:0]  PT0  = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT0  = 64'h44c8fc20_b9dfa07a;
    localparam logic [63:0]  PT2  = 64'h01234567_89abcdef;
    localparam logic [63:0]  PT3  = 64'hfedcba98_76543210;

    task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol32(logic [31:0] v, int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] ror32(logic [31:0] v, int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    // Reference: expand the full key schedule first, then run all rounds.
    function automatic logic [63:0] simonEnc(logic [127:0] key, logic [63:0] blk);
        logic [31:0] rk [44];
        logic [31:0] x, y, tmp;
        logic [61:0] z;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) rk[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp   = ror32(rk[i-1], 3) ^ rk[i-3];
            tmp   = tmp ^ ror32(tmp, 1);
            rk[i] = ~rk[i-4] ^ tmp ^ 32'((z >> (65 - i)) & 62'd1) ^ 32'd3;
        end
        x = blk[63:32];
        y = blk[31:0];
        for (int i = 0; i < 44; i++) begin
            tmp = x;
            x   = y ^ (rol32(x, 1) & rol32(x, 8)) ^ rol32(x, 2) ^ rk[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    function automatic pkt_t mkPkt(logic [7:0] id, logic [7:0] sq, logic [127:0] pl);
        return {id, sq, pl};
    endfunction

    // Scoreboard pop on each rising out_donePKT.
    always @(negedge clk) begin
        if (nR === 1'b1 && bus.in_donePKT === 1'b1) donePulses++;
        if (bus.out_donePKT === 1'b1 && prevOutDone !== 1'b1) begin
            outRises++;
            check("sb_pending", 160'(sbQ.size() != 0), 160'd1);
            if (sbQ.size() != 0) check("sb_out", 160'(bus.out), 160'(sbQ.pop_front()));
        end
        prevOutDone = bus.out_donePKT;
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendPkt(string tag, pkt_t p);
        int cyc;
        bus.in = p;
        bus.in_newPKT = 1'b1;
        cyc = 0;
        while (bus.in_loadPKT !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_load"}, 160'(bus.in_loadPKT), 160'd1);
        bus.in_newPKT = 1'b0;
        cyc = 0;
        while (bus.in_loadPKT !== 1'b0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_release"}, 160'(bus.in_loadPKT), 160'd0);
    endtask

    task automatic waitOut(string tag, output int cyc);
        cyc = 0;
        while (bus.out_donePKT !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_outdone"}, 160'(bus.out_donePKT), 160'd1);
    endtask

    task automatic readOut();
        bus.out_readPKT = 1'b1;
        @(negedge clk);
        bus.out_readPKT = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   d0, r0, cyc;
        pkt_t exp1, exp2, exp3;

        bus.in_newPKT   = 1'b0;
        bus.in          = '0;
        bus.out_readPKT = 1'b0;
        nR = 1'b0;
        tick(3);
        check("rst_outs", 160'({bus.in_loadPKT, bus.in_donePKT, bus.out_donePKT, bus.out}), 160'd0);
        nR = 1'b1;
        tick(2);
        check("idle_load", 160'(bus.in_loadPKT), 160'd0);

        // Key packet: done pulse, no result.
        d0 = donePulses; r0 = outRises;
        sendPkt("key0", mkPkt(ID_KEY, 8'h00, KEY0));
        tick(3);
        check("key_donepulse", 160'(donePulses - d0), 160'd1);
        check("key_noout", 160'(outRises - r0), 160'd0);

        // Reference vector.
        exp1 = mkPkt(ID_DATA, 8'h01, {CT0, CT0});
        sbQ.push_back(exp1);
        sendPkt("data1", mkPkt(ID_DATA, 8'h01, {PT0, PT0}));
        waitOut("data1", cyc);
        check("data1_latency", 160'(cyc >= 2*T && cyc <= 2*T + 4), 160'd1);
        check("data1_donepulse", 160'(bus.in_donePKT), 160'd1);
        tick(5);
        check("data1_hold", 160'({bus.out_donePKT, bus.out}), 160'({1'b1, exp1}));

        // Pending result blocks the next capture until it is read.
        exp2 = mkPkt(ID_DATA, 8'h02, {simonEnc(KEY0, PT2), simonEnc(KEY0, PT3)});
        sbQ.push_back(exp2);
        bus.in = mkPkt(ID_DATA, 8'h02, {PT2, PT3});
        bus.in_newPKT = 1'b1;
        tick(6);
        check("blocked_load", 160'(bus.in_loadPKT), 160'd0);
        check("blocked_outdone", 160'(bus.out_donePKT), 160'd1);
        readOut();
        check("read_clear_keep", 160'({bus.out_donePKT, bus.out}), 160'({1'b0, exp1}));
        sendPkt("data2", mkPkt(ID_DATA, 8'h02, {PT2, PT3}));
        waitOut("data2", cyc);
        readOut();

        // Data with no key after reset is dropped.
        nR = 1'b0;
        tick(2);
        nR = 1'b1;
        tick(2);
        d0 = donePulses; r0 = outRises;
        sendPkt("nokey", mkPkt(ID_DATA, 8'h03, {PT0, PT0}));
        tick(2*T + 10);
        check("nokey_donepulse", 160'(donePulses - d0), 160'd1);
        check("nokey_noout", 160'(outRises - r0), 160'd0);

        // Unknown identifier is dropped even with a valid key.
        sendPkt("key0b", mkPkt(ID_KEY, 8'h00, KEY0));
        tick(2);
        d0 = donePulses; r0 = outRises;
        sendPkt("badid", mkPkt(8'h7F, 8'h04, {PT0, PT0}));
        tick(2*T + 10);
        check("badid_donepulse", 160'(donePulses - d0), 160'd1);
        check("badid_noout", 160'(outRises - r0), 160'd0);

        // Reset in the middle of a run aborts it.
        r0 = outRises;
        sendPkt("abort", mkPkt(ID_DATA, 8'h05, {PT0, PT0}));
        tick(20);
        nR = 1'b0;
        #1;
        check("abort_rst_outs", 160'({bus.in_loadPKT, bus.in_donePKT, bus.out_donePKT, bus.out}), 160'd0);
        tick(2);
        nR = 1'b1;
        tick(2*T + 10);
        check("abort_noout", 160'(outRises - r0), 160'd0);

        // Re-key with a new key, then encrypt.
        sendPkt("key1", mkPkt(ID_KEY, 8'h00, KEY1));
        tick(2);
        exp3 = mkPkt(ID_DATA, 8'h06, {simonEnc(KEY1, PT2), simonEnc(KEY1, PT0)});
        sbQ.push_back(exp3);
        sendPkt("data3", mkPkt(ID_DATA, 8'h06, {PT2, PT0}));
        waitOut("data3", cyc);
        readOut();

        // Switching back to the original key affects only later data.
        sendPkt("key0c", mkPkt(ID_KEY, 8'h00, KEY0));
        tick(2);
        sbQ.push_back(mkPkt(ID_DATA, 8'h07, {CT0, simonEnc(KEY0, PT3)}));
        sendPkt("data4", mkPkt(ID_DATA, 8'h07, {PT0, PT3}));
        waitOut("data4", cyc);
        readOut();

        tick(3);
        check("sb_empty", 160'(sbQ.size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
